// File: rtl/boo_response_checker_if.sv
// Sample bus carrying one observation of the 3-input Boolean block:
// the applied inputs {a,b,c}, the observed output y, and a qualifier.
interface boo_response_checker_if;
    logic sample_valid;
    logic a;
    logic b;
    logic c;
    logic y;

    modport master (output sample_valid, a, b, c, y);
    modport slave  (input  sample_valid, a, b, c, y);
endinterface

// File: rtl/boo_response_checker.sv
// Response checker for a 3-input Boolean block: compares samples against a truth table,
// counts mismatches, captures the first failing index and tracks input-space coverage.
module boo_response_checker #(
    parameter logic [7:0] TRUTH_TABLE = 8'b1110_1000,
    parameter int         ERR_W       = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    boo_response_checker_if.slave    smp,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic [ERR_W-1:0]         err_count,
    output logic [7:0]               seen_mask,
    output logic                     first_fail_valid,
    output logic [2:0]               first_fail_idx
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;

    logic [2:0]       idx;
    logic             mismatch;
    logic [7:0]       seen_next;
    logic [ERR_W-1:0] err_next;

    always_comb begin
        idx       = {smp.a, smp.b, smp.c};
        mismatch  = (smp.y != TRUTH_TABLE[idx]);
        seen_next = seen_mask | (8'b0000_0001 << idx);
        err_next  = err_count;
        if (mismatch && (err_count != {ERR_W{1'b1}})) begin
            err_next = err_count + ERR_W'(1);
        end
    end

    // busy/done are registered alongside the state so they can never glitch or overlap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= '0;
            seen_mask        <= 8'h00;
            first_fail_valid <= 1'b0;
            first_fail_idx   <= 3'd0;
        end else if (start) begin
            state            <= RUN;
            busy             <= 1'b1;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= '0;
            seen_mask        <= 8'h00;
            first_fail_valid <= 1'b0;
            first_fail_idx   <= 3'd0;
        end else if ((state == RUN) && smp.sample_valid) begin
            seen_mask <= seen_next;
            err_count <= err_next;
            if (mismatch && !first_fail_valid) begin
                first_fail_valid <= 1'b1;
                first_fail_idx   <= idx;
            end
            if (seen_next == 8'hFF) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
                pass  <= (err_next == '0);
            end
        end
    end

endmodule

// File: tb/tb_boo_response_checker.sv
// Directed bench for boo_response_checker: a majority-function reference model checked every
// cycle against two instances (ERR_W=8 and ERR_W=2), plus hand-computed literal expectations.
module tb_boo_response_checker;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0;
    boo_response_checker_if bus ();

    logic       busy8, done8, pass8, ffv8;
    logic [7:0] err8, mask8;
    logic [2:0] ffi8;
    logic       busy2, done2, pass2, ffv2;
    logic [1:0] err2;
    logic [7:0] mask2;
    logic [2:0] ffi2;

    int vectors = 0;
    int miscompares = 0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;

    boo_response_checker #(.TRUTH_TABLE(8'b1110_1000), .ERR_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .smp(bus),
        .busy(busy8), .done(done8), .pass(pass8), .err_count(err8),
        .seen_mask(mask8), .first_fail_valid(ffv8), .first_fail_idx(ffi8)
    );

    boo_response_checker #(.TRUTH_TABLE(8'b1110_1000), .ERR_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .smp(bus),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
        .seen_mask(mask2), .first_fail_valid(ffv2), .first_fail_idx(ffi2)
    );

    // Reference model: a run is a set of seen indices plus a raw mismatch tally.
    bit m_run = 1'b0;
    bit m_done = 1'b0;
    bit m_pass = 1'b0;
    int m_errs = 0;
    bit m_seen [8];
    bit m_ffv = 1'b0;
    int m_ffi = 0;

    function automatic logic [7:0] model_mask();
        logic [7:0] m;
        m = 8'h00;
        for (int i = 0; i < 8; i++) if (m_seen[i]) m[i] = 1'b1;
        return m;
    endfunction

    function automatic int sat(input int n, input int w);
        int top;
        top = (1 << w) - 1;
        return (n > top) ? top : n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int s_idx;
        bit s_exp;
        bit all_seen;
        if (!rst_n) begin
            m_run = 0; m_done = 0; m_pass = 0; m_errs = 0; m_ffv = 0; m_ffi = 0;
            for (int i = 0; i < 8; i++) m_seen[i] = 0;
        end else if (start) begin
            m_run = 1; m_done = 0; m_pass = 0; m_errs = 0; m_ffv = 0; m_ffi = 0;
            for (int i = 0; i < 8; i++) m_seen[i] = 0;
        end else if (m_run && bus.sample_valid) begin
            s_idx = 4 * int'(bus.a) + 2 * int'(bus.b) + int'(bus.c);
            s_exp = (int'(bus.a) + int'(bus.b) + int'(bus.c)) >= 2;
            m_seen[s_idx] = 1;
            if (bus.y != s_exp) begin
                m_errs++;
                if (!m_ffv) begin
                    m_ffv = 1;
                    m_ffi = s_idx;
                end
            end
            all_seen = 1;
            for (int i = 0; i < 8; i++) if (!m_seen[i]) all_seen = 0;
            if (all_seen) begin
                m_run = 0;
                m_done = 1;
                m_pass = (m_errs == 0);
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("busy8",  32'(busy8),  32'(m_run));
            checkOutput("done8",  32'(done8),  32'(m_done));
            checkOutput("pass8",  32'(pass8),  32'(m_pass));
            checkOutput("err8",   32'(err8),   32'(sat(m_errs, 8)));
            checkOutput("mask8",  32'(mask8),  32'(model_mask()));
            checkOutput("ffv8",   32'(ffv8),   32'(m_ffv));
            checkOutput("ffi8",   32'(ffi8),   32'(m_ffi));
            checkOutput("busy2",  32'(busy2),  32'(m_run));
            checkOutput("done2",  32'(done2),  32'(m_done));
            checkOutput("pass2",  32'(pass2),  32'(m_pass));
            checkOutput("err2",   32'(err2),   32'(sat(m_errs, 2)));
            checkOutput("mask2",  32'(mask2),  32'(model_mask()));
            checkOutput("ffi2",   32'(ffi2),   32'(m_ffi));
        end
    end

    task automatic applyStimulus(input bit st, input bit vld, input logic [2:0] abc, input bit yv);
        @(posedge clk);
        #1;
        start = st;
        bus.sample_valid = vld;
        {bus.a, bus.b, bus.c} = abc;
        bus.y = yv;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 3'd0, 1'b0);
    endtask

    logic [7:0] maj_tab;

    initial begin
        maj_tab = 8'b1110_1000;
        bus.sample_valid = 1'b0;
        bus.a = 1'b0; bus.b = 1'b0; bus.c = 1'b0; bus.y = 1'b0;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check_en = 1'b1;
        checkOutput("reset_busy", 32'(busy8), 32'd0);
        checkOutput("reset_mask", 32'(mask8), 32'd0);

        // Clean run
        applyStimulus(1, 0, 3'd0, 0);
        for (int i = 0; i < 8; i++) applyStimulus(0, 1, 3'(i), maj_tab[i]);
        idle();
        checkOutput("clean_done", 32'(done8), 32'd1);
        checkOutput("clean_busy", 32'(busy8), 32'd0);
        checkOutput("clean_pass", 32'(pass8), 32'd1);
        checkOutput("clean_err",  32'(err8),  32'd0);
        checkOutput("clean_mask", 32'(mask8), 32'hFF);
        checkOutput("clean_ffv",  32'(ffv8),  32'd0);
        // Samples in DONE must be ignored
        applyStimulus(0, 1, 3'd0, 1);
        idle();
        checkOutput("done_hold_err", 32'(err8), 32'd0);

        // Single fault at 101
        applyStimulus(1, 0, 3'd0, 0);
        for (int i = 0; i < 8; i++) applyStimulus(0, 1, 3'(i), (i == 5) ? 1'b0 : maj_tab[i]);
        idle();
        checkOutput("single_err", 32'(err8), 32'd1);
        checkOutput("single_ffi", 32'(ffi8), 32'd5);
        checkOutput("single_ffv", 32'(ffv8), 32'd1);
        checkOutput("single_pass", 32'(pass8), 32'd0);

        // Multiple faults at 010 then 110
        applyStimulus(1, 0, 3'd0, 0);
        for (int i = 0; i < 8; i++) applyStimulus(0, 1, 3'(i), (i == 2 || i == 6) ? ~maj_tab[i] : maj_tab[i]);
        idle();
        checkOutput("multi_ffi", 32'(ffi8), 32'd2);
        checkOutput("multi_err", 32'(err8), 32'd2);
        checkOutput("multi_done", 32'(done8), 32'd1);

        // Saturation on the narrow counter with idle gaps
        applyStimulus(1, 0, 3'd0, 0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 1, 3'd0, 1);
            idle();
            idle();
        end
        checkOutput("sat_err2",  32'(err2),  32'h3);
        checkOutput("sat_err8",  32'(err8),  32'd10);
        checkOutput("sat_mask",  32'(mask2), 32'h01);
        checkOutput("sat_busy",  32'(busy2), 32'd1);
        checkOutput("sat_done",  32'(done2), 32'd0);

        // Restart after 4 samples; a sample alongside start is ignored
        applyStimulus(1, 0, 3'd0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 3'(i), ~maj_tab[i]);
        applyStimulus(1, 1, 3'd7, 0);
        idle();
        checkOutput("restart_err",  32'(err8),  32'd0);
        checkOutput("restart_mask", 32'(mask8), 32'h00);
        checkOutput("restart_ffv",  32'(ffv8),  32'd0);
        checkOutput("restart_busy", 32'(busy8), 32'd1);
        for (int i = 7; i >= 0; i--) applyStimulus(0, 1, 3'(i), maj_tab[i]);
        idle();
        checkOutput("restart_pass", 32'(pass8), 32'd1);
        checkOutput("restart_done", 32'(done8), 32'd1);

        // Start held for two cycles, then asynchronous reset mid-run
        applyStimulus(1, 0, 3'd0, 0);
        applyStimulus(1, 1, 3'd1, 1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 3'(i), ~maj_tab[i]);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_busy", 32'(busy8), 32'd0);
        checkOutput("rst_done", 32'(done8), 32'd0);
        checkOutput("rst_err",  32'(err8),  32'd0);
        checkOutput("rst_mask", 32'(mask8), 32'h00);
        checkOutput("rst_ffv",  32'(ffv8),  32'd0);
        checkOutput("rst_ffi",  32'(ffi8),  32'd0);
        checkOutput("rst_pass", 32'(pass8), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) applyStimulus(0, 1, 3'(i), 1'b1);
        idle();
        checkOutput("post_rst_mask", 32'(mask8), 32'h00);
        checkOutput("post_rst_busy", 32'(busy8), 32'd0);
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/boo_response_checker.md
# boo_response_checker

Synthesizable response checker for the 3-input Boolean function block. It sits on the DUT's output side and samples `{a,b,c}` together with the DUT's `y`. Each sample is compared against a parameterised 8-entry truth table. The block counts mismatches, records the first failing input combination, and tracks coverage of all 8 input combinations. It declares the run done once every combination has been seen, so the exhaustive stimulus sequence can be verified on silicon or FPGA without inspecting waveforms.

## Interface
- `TRUTH_TABLE`, default `8'b1110_1000`: expected `y`; bit index = `{a,b,c}`. The default is the majority function.
- `ERR_W`, default 8: width of the saturating error counter (≥1).

Ports:
- `clk`, input, 1: single clock; all logic on its rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: single-cycle pulse; clears results and begins a run.
- `sample_valid`, input, 1: `a`, `b`, `c`, `y` are valid this cycle.
- `a`, `b`, `c`, input, 1 each: DUT inputs as applied.
- `y`, input, 1: DUT output for those inputs.
- `busy`, output, 1: high in RUN state.
- `done`, output, 1: high in DONE state.
- `pass`, output, 1: valid when `done`=1; 1 iff `err_count`==0.
- `err_count`, output, ERR_W: number of mismatching samples, saturating at all-ones.
- `seen_mask`, output, 8: bit i set once index i has been sampled in this run.
- `first_fail_valid`, output, 1: a mismatch has been captured this run.
- `first_fail_idx`, output, 3: `{a,b,c}` of the first mismatch.

## Operation
- FSM states and transitions:
  - IDLE → RUN on `start`.
  - RUN → DONE when `seen_mask` reaches 8'hFF, counting the current sample.
  - DONE → RUN on `start`.
  - There is no other exit from DONE.
- `start` (any state, including RUN):
  - clears `err_count`, `seen_mask`, `first_fail_valid`, `first_fail_idx` and `pass`;
  - enters RUN;
  - any `sample_valid` in the same cycle is ignored.
- In RUN, each cycle with `sample_valid`=1:
  - idx = `{a,b,c}`; exp = `TRUTH_TABLE[idx]`.
  - `seen_mask[idx]` ← 1.
  - If `y` != exp: `err_count` increments; at all-ones it holds.
  - If `y` != exp and `first_fail_valid`=0: `first_fail_idx` ← idx and `first_fail_valid` ← 1. Later mismatches do not overwrite it.
  - Duplicate indices are checked and counted normally but add no coverage.
- Samples are ignored in IDLE and DONE. All outputs hold their values in those states.
- `pass` is registered on entry to DONE. It equals (`err_count` after the final sample == 0).
- `busy` and `done` are decoded from the state register; they are never high together.

## Timing
- Reset values of all outputs: `busy`=0, `done`=0, `pass`=0, `err_count`=0, `seen_mask`=0, `first_fail_valid`=0, `first_fail_idx`=0. The state is IDLE.
- Reset asserted mid-run forces reset values immediately, regardless of the clock.
- Latency: every output reflects a sample on the first rising edge after that sample (1 cycle).
- `start` at edge N gives `busy`=1 and cleared results after edge N.
- Completion: if the 8th distinct index is sampled at edge N, then after edge N:
  - `done`=1, `busy`=0;
  - `pass`, `err_count` and `seen_mask`=8'hFF all include that sample.
- Back-to-back `sample_valid` is allowed every cycle. There is no backpressure.
- `sample_valid` may stay low for any number of cycles. RUN has no timeout.
- Only the cycle where `start` is high counts. `start` held high for multiple cycles re-clears on each of them.

## Test plan
- Clean run: `start`, then samples 000..111 with correct `y` (0,0,0,1,0,1,1,1) on consecutive cycles.
  - Required: `done`=1 one cycle after the 111 sample; `pass`=1, `err_count`=0, `seen_mask`=8'hFF, `first_fail_valid`=0.
- Single fault: as the clean run, but `y`=0 at index 101.
  - Required: `err_count`=1, `first_fail_idx`=3'b101, `first_fail_valid`=1, `pass`=0.
- Multiple faults: inverted `y` at 010, then at 110.
  - Required: `first_fail_idx`=3'b010 (not overwritten), `err_count`=2.
- Saturation and coverage (`ERR_W`=2): 10 wrong samples of index 000 with idle gaps.
  - Required: `err_count`=2'b11, `seen_mask`=8'h01, `busy`=1, `done`=0.
- Restart: `start` pulsed after 4 samples, then all 8 correct samples.
  - Required: counters clear one cycle after `start`; the run completes with `pass`=1.
- Reset: `rst_n` pulled low mid-run.
  - Required: all outputs return to 0 immediately. After release, samples are ignored until `start`; `seen_mask` stays 8'h00.
